// File: rtl/ram_rmw_bridge.sv
// Sub-word load/store bridge onto a word-only RAM; partial stores use read-modify-write.
// Optional misalignment checking is enabled by defining RAM_MISALIGN_CHECK_EN.
module ram_rmw_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy_q;
  logic              ack_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mis_d;

  // Insert the store lanes into the word read from RAM; size 11 behaves as word.
  function automatic logic [DATA_W-1:0] merge_word(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [1:0]        lane,
                                                   input logic [1:0]        size);
    logic [DATA_W-1:0] w;
    w = old_w;
    case (size)
      2'b00:   w[{lane, 3'b000} +: 8] = new_w[7:0];
      2'b01:   w[{lane[1], 4'b0000} +: 16] = new_w[15:0];
      default: w = new_w;
    endcase
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract_word(input logic [DATA_W-1:0] w,
                                                     input logic [1:0]        lane,
                                                     input logic [1:0]        size);
    logic [DATA_W-1:0] r;
    r = '0;
    case (size)
      2'b00:   r[7:0] = w[{lane, 3'b000} +: 8];
      2'b01:   r[15:0] = w[{lane[1], 4'b0000} +: 16];
      default: r = w;
    endcase
    return r;
  endfunction

`ifdef RAM_MISALIGN_CHECK_EN
  logic err_q;

  always_comb begin
    case (size_i)
      2'b00:   mis_d = 1'b0;
      2'b01:   mis_d = addr_i[0];
      default: mis_d = |addr_i[1:0];
    endcase
  end

  // Raised together with the direct IDLE->RESP jump, so it lines up with ack_o.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == IDLE) && req_i && mis_d;
  end

  assign err_o = err_q;
`else
  assign mis_d = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= 2'b00;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q       <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            size_q  <= size_i;
            wdata_q <= wdata_i;
            busy_q  <= 1'b1;
            if (mis_d) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
            end else if (we_i && size_i[1]) begin
              state_q     <= WR;
              ram_we_q    <= 1'b1;
              ram_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
              ram_wdata_q <= wdata_i;
            end else begin
              state_q    <= RD;
              ram_addr_q <= {addr_i[ADDR_W-1:2], 2'b00};
            end
          end
        end
        RD: begin
          if (we_q) begin
            state_q     <= WR;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= {addr_q[ADDR_W-1:2], 2'b00};
            ram_wdata_q <= merge_word(ram_rdata_i, wdata_q, addr_q[1:0], size_q);
          end else begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            rdata_q <= extract_word(ram_rdata_i, addr_q[1:0], size_q);
          end
        end
        WR: begin
          state_q <= RESP;
          ack_q   <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  // A reset arriving during WR must suppress the write on the edge that ends it.
  assign ram_we_o    = ram_we_q & ~rst;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_ram_rmw_bridge.sv
// Bench for ram_rmw_bridge: word RAM model, directed vector table, reset/hold/misalign
// sequences and randomized traffic against an arithmetic reference memory.
module tb_ram_rmw_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] wdata_i = '0;
  logic        busy_o, ack_o, err_o, ram_we_o;
  logic [31:0] rdata_o, ram_addr_o, ram_wdata_o, ram_rdata_i;

  int checks = 0;
  int failures = 0;
  int we_pulses = 0;
  int ack_pulses = 0;
  logic init_mem = 1'b1;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  ram_rmw_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .size_i(size_i), .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o),
    .rdata_o(rdata_o), .err_o(err_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
  endfunction

  // Word-only RAM with combinational read.
  assign ram_rdata_i = mem[ram_addr_o[7:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
    end else if (ram_we_o) begin
      mem[ram_addr_o[7:2]] <= ram_wdata_o;
    end
    if (ram_we_o) we_pulses <= we_pulses + 1;
    if (ack_o) ack_pulses <= ack_pulses + 1;
  end

  always @(negedge clk) begin
    checks++;
    if (ram_addr_o[1:0] != 2'b00) begin
      failures++;
      $display("FAIL ram_addr_align actual=%h required low bits 00", ram_addr_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: access width in bytes, byte offset within the word, lane mask.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef RAM_MISALIGN_CHECK_EN
    return (int'(addr % 4) % nbytes(size)) != 0;
`else
    return (size === 2'bxx) && (addr === 32'hx);
`endif
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wd, input logic hold,
                         output logic [31:0] rd_got, output int lat_got);
    int idx, n, off, w0, a0, alt_idx, exp_lat, exp_pulses;
    logic mis, err_got, busy_at_ack;
    logic [31:0] msk, old_w, exp_rd, alt_w;
    idx = int'(addr[7:2]);
    n = nbytes(size);
    off = int'(addr % 4) / n * n;
    msk = lane_mask(n);
    mis = is_mis(size, addr);
    old_w = ref_mem[idx];
    exp_rd = '0;
    exp_pulses = 0;
    if (mis) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      exp_rd = (old_w >> (8 * off)) & msk;
    end else begin
      exp_lat = (n == 4) ? 2 : 3;
      exp_pulses = 1;
      ref_mem[idx] = (old_w & ~(msk << (8 * off))) | ((wd & msk) << (8 * off));
    end
    alt_idx = idx ^ 16;
    alt_w = ref_mem[alt_idx];

    @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'd0);
    w0 = we_pulses;
    a0 = ack_pulses;
    req_i = 1'b1; we_i = we; addr_i = addr; size_i = size; wdata_i = wd;
    @(negedge clk);
    if (hold) begin
      we_i = 1'b1; addr_i = addr ^ 32'h40; size_i = 2'b10; wdata_i = ~wd;
    end else begin
      req_i = 1'b0; we_i = 1'($urandom_range(0, 1)); addr_i = $urandom;
      size_i = 2'($urandom_range(0, 3)); wdata_i = $urandom;
    end
    lat_got = 1;
    while (ack_o !== 1'b1 && lat_got < 8) begin
      @(negedge clk);
      lat_got++;
    end
    rd_got = rdata_o;
    err_got = err_o;
    busy_at_ack = busy_o;
    req_i = 1'b0;
    @(negedge clk);
    check("latency", 32'(lat_got), 32'(exp_lat));
    check("rdata", rd_got, exp_rd);
    check("err", 32'(err_got), 32'(mis));
    check("busy_in_resp", 32'(busy_at_ack), 32'd1);
    check("busy_after", 32'(busy_o), 32'd0);
    check("ram_we_pulses", 32'(we_pulses - w0), 32'(exp_pulses));
    check("ack_count", 32'(ack_pulses - a0), 32'd1);
    check("ram_word", mem[idx], ref_mem[idx]);
    if (hold) check("hold_other_word", mem[alt_idx], alt_w);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] rd;
    int lat;
    logic [31:0] old_w;
    int a0;

    vecs[0]  = '{1'b1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0,        2, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h11, 2'b00, 32'h0,        32'h000000BE, 2, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20, 2'b10, 32'h11223344, 32'h0,        2, 32'h11223344};
    vecs[3]  = '{1'b1, 32'h22, 2'b00, 32'h000000AA, 32'h0,        3, 32'h11AA3344};
    vecs[4]  = '{1'b1, 32'h20, 2'b11, 32'h11223344, 32'h0,        2, 32'h11223344};
    vecs[5]  = '{1'b1, 32'h22, 2'b01, 32'h00005566, 32'h0,        3, 32'h55663344};
    vecs[6]  = '{1'b0, 32'h20, 2'b01, 32'h0,        32'h00003344, 2, 32'h55663344};
    vecs[7]  = '{1'b0, 32'h20, 2'b10, 32'h0,        32'h55663344, 2, 32'h55663344};
    vecs[8]  = '{1'b0, 32'h23, 2'b00, 32'h0,        32'h00000055, 2, 32'h55663344};
    vecs[9]  = '{1'b0, 32'h22, 2'b01, 32'h0,        32'h00005566, 2, 32'h55663344};
    vecs[10] = '{1'b1, 32'h10, 2'b00, 32'hFFFFFF77, 32'h0,        3, 32'hDEADBE77};
    vecs[11] = '{1'b0, 32'h10, 2'b11, 32'h0,        32'hDEADBE77, 2, 32'hDEADBE77};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_ram_we", 32'(ram_we_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_ram_addr", ram_addr_o, 32'd0);
    check("rst_ram_wdata", ram_wdata_o, 32'd0);
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    init_mem = 1'b0;
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, rd, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_word", i), mem[vecs[i].addr[7:2]], vecs[i].exp_word);
    end

    // req_i held high while busy, retargeted at another word
    run_txn(1'b1, 32'h14, 2'b10, 32'hCAFEF00D, 1'b1, rd, lat);
    check("hold_word", mem[5], 32'hCAFEF00D);
    check("hold_other", mem[21], seed_word(21));

    // Misaligned word store
    run_txn(1'b1, 32'h41, 2'b10, 32'h12345678, 1'b0, rd, lat);
`ifdef RAM_MISALIGN_CHECK_EN
    check("misalign_latency", 32'(lat), 32'd1);
    check("misalign_word", mem[16], seed_word(16));
`else
    check("misalign_latency", 32'(lat), 32'd2);
    check("misalign_word", mem[16], 32'h12345678);
`endif

    // Reset during the WR cycle of a byte store to 0x30
    @(negedge clk);
    old_w = mem[12];
    a0 = ack_pulses;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; size_i = 2'b00; wdata_i = 32'h99;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("abort_in_wr", 32'(ram_we_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_word", mem[12], old_w);
    check("abort_ack", 32'(ack_pulses - a0), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_ram_we", 32'(ram_we_o), 32'd0);
    check("abort_ram_addr", ram_addr_o, 32'd0);
    check("abort_ram_wdata", ram_wdata_o, 32'd0);
    check("abort_rdata", rdata_o, 32'd0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
              2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0), rd, lat);
    end
    for (int i = 0; i < 64; i++) check($sformatf("final_word%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_rmw_bridge.md
# ram_rmw_bridge

Sub-word access bridge between the core's data-bus master port and the word-only data RAM. The RAM performs whole-word writes only and returns a combinational read of the word at `addr[31:2]`. This block turns byte, halfword and word loads and stores into aligned word accesses, using a read-modify-write sequence for partial stores. It returns lane-extracted load data with a single-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk` input, 1: clock.
- `rst` input, 1: reset, synchronous, active-high.
- `req_i` input, 1: request strobe. Sampled only when `busy_o`=0.
- `we_i` input, 1: 1 = store, 0 = load.
- `addr_i` input, ADDR_W: byte address.
- `size_i` input, 2: 00 = byte, 01 = halfword, 10 = word. 11 is treated as word.
- `wdata_i` input, 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `busy_o` output, 1: bridge holds an accepted request.
- `ack_o` output, 1: one-cycle completion pulse.
- `rdata_o` output, 32: load result, zero-extended and right-aligned. Valid only while `ack_o`=1, otherwise 0.
- `err_o` output, 1: misalignment flag, qualified by `ack_o`.
- `ram_we_o` output, 1: RAM write enable.
- `ram_addr_o` output, ADDR_W: RAM address. Bits [1:0] are always 00.
- `ram_wdata_o` output, 32: RAM write word.
- `ram_rdata_i` input, 32: RAM combinational read word.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE, with `req_i`=1: latch `we_i`, `addr_i`, `size_i` and `wdata_i`, set `busy_o`=1, then go to:
  - RD for any load;
  - RD for a byte or halfword store;
  - WR for a word store;
  - RESP directly for a misaligned access (see Configuration).
- The requester may drop `req_i` after acceptance. While `busy_o`=1, `req_i` is ignored and is never queued.
- RD:
  - Drive `ram_addr_o` = {latched addr[31:2], 2'b00}.
  - Capture `ram_rdata_i` into the word register.
  - Next state: WR for a store, RESP for a load.
- WR:
  - `ram_we_o`=1, `ram_addr_o` as in RD.
  - `ram_wdata_o` is the merged word:
    - byte: lane = addr[1:0], taking `wdata_i[7:0]`;
    - halfword: addr[1]=0 replaces bits [15:0], addr[1]=1 replaces bits [31:16], taking `wdata_i[15:0]`;
    - word: `wdata_i` unchanged.
  - All bytes not written keep the captured word's values. Next state: RESP.
- RESP:
  - `ack_o`=1, `busy_o`=1.
  - For a load, `rdata_o` carries the selected byte or halfword from the captured word (same lane rules as WR), zero-extended; for a word load, the full captured word.
  - For a store, `rdata_o`=0.
  - Next state: IDLE. `busy_o` falls in the following cycle.
- `ram_we_o`, `ram_addr_o` and `ram_wdata_o` are decoded from the state and latched registers only, so they are glitch-free relative to the bus inputs.
- Outside RD and WR, `ram_addr_o`=0 and `ram_wdata_o`=0.

## Timing
- Reset (synchronous): state=IDLE; `busy_o`, `ack_o`, `err_o`, `ram_we_o`=0; `rdata_o`, `ram_addr_o`, `ram_wdata_o`=0; latched registers=0.
- Reset asserted mid-operation (RD or WR) aborts the operation. A WR in progress at the reset edge is not written, because `ram_we_o` is 0 from that edge onward. No `ack_o` is issued for the aborted request.
- Latency from the accept edge to the `ack_o` cycle:
  - load: 2 cycles (RD, RESP);
  - word store: 2 cycles (WR, RESP);
  - partial store: 3 cycles (RD, WR, RESP);
  - misaligned access with the check enabled: 1 cycle (RESP).
- Issue rate: at most one request per (latency + 1) cycles. A new request can be accepted in the cycle after RESP.
- The RAM write happens on the clk edge that ends the WR state.

## Configuration
- Macro `RAM_MISALIGN_CHECK_EN`, when defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠00, is misaligned.
  - A misaligned access goes IDLE→RESP with no RAM access and `ram_we_o` never asserted.
  - In RESP: `err_o`=1, `rdata_o`=0.
- When undefined:
  - `err_o` is tied to 0.
  - Halfword ignores addr[0]; word ignores addr[1:0]. The access proceeds aligned down.

## Test plan
- Word store 0xDEADBEEF at 0x10, then byte load at 0x11 → `ram_we_o` pulses exactly 1 cycle; `ack_o` arrives 2 cycles after each accept; `rdata_o`=0x000000BE.
- Word 0x11223344 at 0x20, then byte store 0xAA at 0x22 → RAM word becomes 0x11AA3344; `ack_o` arrives 3 cycles after accept.
- Halfword store 0x5566 at 0x22 over word 0x11223344 → RAM word becomes 0x55663344. Halfword load at 0x20 → `rdata_o`=0x00003344.
- `req_i` held high during `busy_o` with a different address → the second request is ignored; exactly one `ack_o` is issued; the RAM is unchanged by the second request.
- `rst` asserted in the WR cycle of a byte store to 0x30 → the RAM word at 0x30 is unchanged; `ack_o`=0; all outputs are 0 on the next cycle.
- With `RAM_MISALIGN_CHECK_EN`, word store at 0x41 → `ack_o` and `err_o` 1 cycle after accept, `ram_we_o` never asserted. Without the macro, the same access writes word 0x40 and `err_o`=0.
